// File: rtl/aes_pkg.sv
// Shared definitions for the AES round sequencer.
//   aes_state_e : sequencer FSM encoding
//   NR_DEFAULT  : default number of cipher rounds (AES-128)
//   AES_W       : block / key width
//   RC_W        : width of the round counter and rnd_rc output
package aes_pkg;

  localparam int NR_DEFAULT = 10;
  localparam int AES_W      = 128;
  localparam int RC_W       = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RUN  = 3'd2,
    LAST = 3'd3,
    DONE = 3'd4
  } aes_state_e;

endpackage

// File: rtl/aes_round_seq.sv
// AES round sequencer. It holds the cipher state, the current round key and the
// round counter. It steps an external full-round datapath once per round, then
// captures the result of an external final-round unit as the ciphertext.
//
// Ports
//   clk, rst_n   : clock (rising edge) and asynchronous active-low reset
//   start        : request, accepted only in IDLE
//   plaintext    : input block, sampled with an accepted start
//   key          : cipher key, sampled with an accepted start
//   busy         : high while an operation is in flight (LOAD/RUN/LAST)
//   done         : one-cycle pulse when ciphertext becomes valid
//   ciphertext   : result, held until the next final-round capture
//   rnd_start    : request to the round datapaths (RUN/LAST)
//   rnd_rc       : current round index
//   rnd_data     : state register
//   rnd_key      : round-key register
//   rnd_next     : datapath result valid; low stalls the sequencer
//   rnd_out      : full-round result
//   rnd_keyout   : next round key
//   fin_out      : final-round result
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; outputs quiet, ciphertext held
// LOAD  | initial AddRoundKey result is in the state register
// RUN   | full rounds 1..NR-1, one per rnd_next
// LAST  | final round NR, ciphertext captured on rnd_next
// DONE  | done pulse, back to IDLE
module aes_round_seq
  import aes_pkg::*;
#(
  parameter int NR = NR_DEFAULT,
  parameter int W  = AES_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [W-1:0]    plaintext,
  input  logic [W-1:0]    key,
  output logic            busy,
  output logic            done,
  output logic [W-1:0]    ciphertext,
  output logic            rnd_start,
  output logic [RC_W-1:0] rnd_rc,
  output logic [W-1:0]    rnd_data,
  output logic [W-1:0]    rnd_key,
  input  logic            rnd_next,
  input  logic [W-1:0]    rnd_out,
  input  logic [W-1:0]    rnd_keyout,
  input  logic [W-1:0]    fin_out
);

  localparam logic [RC_W-1:0] NR_RC = RC_W'(NR);

  aes_state_e      state_q, state_d;
  logic [RC_W-1:0] cnt_q;
  logic [RC_W-1:0] cnt_inc;
  logic [W-1:0]    data_q;
  logic [W-1:0]    key_q;
  logic [W-1:0]    ct_q;
  logic            ld_init;
  logic            ld_round;
  logic            ld_ct;

  assign cnt_inc = cnt_q + RC_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ld_init   = 1'b0;
    ld_round  = 1'b0;
    ld_ct     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    rnd_start = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          ld_init = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        busy = 1'b1;
        // A single-round cipher has no full rounds, so it goes straight to LAST.
        state_d = (cnt_q == NR_RC) ? LAST : RUN;
      end
      RUN: begin
        busy      = 1'b1;
        rnd_start = 1'b1;
        if (rnd_next) begin
          ld_round = 1'b1;
          if (cnt_inc == NR_RC) begin
            state_d = LAST;
          end
        end
      end
      LAST: begin
        busy      = 1'b1;
        rnd_start = 1'b1;
        if (rnd_next) begin
          ld_ct   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The counter only advances in RUN, and RUN is left on the edge that loads NR,
  // so the counter never exceeds NR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      data_q <= '0;
      key_q  <= '0;
      ct_q   <= '0;
    end else begin
      if (ld_init) begin
        data_q <= plaintext ^ key;
        key_q  <= key;
        cnt_q  <= RC_W'(1);
      end else if (ld_round) begin
        data_q <= rnd_out;
        key_q  <= rnd_keyout;
        cnt_q  <= cnt_inc;
      end
      if (ld_ct) begin
        ct_q <= fin_out;
      end
    end
  end

  assign rnd_rc     = cnt_q;
  assign rnd_data   = data_q;
  assign rnd_key    = key_q;
  assign ciphertext = ct_q;

endmodule

// File: tb/tb_aes_round_seq.sv
// Bench for aes_round_seq. It provides behavioural AES-128 round and
// final-round datapaths, which are combinational from the sequencer's
// registers. It checks published AES-128 vectors, stalls, ignored starts,
// mid-operation reset and back-to-back operation.
module tb_aes_round_seq;

  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT2 = 128'h3925841d02dc09fbdc118597196a0b32;

  localparam logic [2047:0] SBOX = 2048'h637c777bf26b6fc53001672bfed7ab76_ca82c97dfa5947f0add4a2af9ca472c0_b7fd9326363ff7cc34a5e5f171d83115_04c723c31896059a071280e2eb27b275_09832c1a1b6e5aa0523bd6b329e32f84_53d100ed20fcb15b6acbbe394a4c58cf_d0efaafb434d338545f9027f503c9fa8_51a3408f929d38f5bcb6da2110fff3d2_cd0c13ec5f974417c4a77e3d645d1973_60814fdc222a908846eeb814de5e0bdb_e0323a0a4906245cc2d3ac629195e479_e7c8376d8dd54ea96c56f4ea657aae08_ba78252e1ca6b4c6e8dd741f4bbd8b8a_703eb5664803f60e613557b986c11d9e_e1f8981169d98e949b1e87e9ce5528df_8ca1890dbfe6426841992d0fb054bb16;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [127:0] plaintext;
  logic [127:0] key;
  logic         busy;
  logic         done;
  logic [127:0] ciphertext;
  logic         rnd_start;
  logic [3:0]   rnd_rc;
  logic [127:0] rnd_data;
  logic [127:0] rnd_key;
  logic         rnd_next;
  logic [127:0] rnd_out;
  logic [127:0] rnd_keyout;
  logic [127:0] fin_out;

  int checks = 0;
  int errors = 0;

  aes_round_seq #(.NR(10), .W(128)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .plaintext  (plaintext),
    .key        (key),
    .busy       (busy),
    .done       (done),
    .ciphertext (ciphertext),
    .rnd_start  (rnd_start),
    .rnd_rc     (rnd_rc),
    .rnd_data   (rnd_data),
    .rnd_key    (rnd_key),
    .rnd_next   (rnd_next),
    .rnd_out    (rnd_out),
    .rnd_keyout (rnd_keyout),
    .fin_out    (fin_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] sb(input logic [7:0] x);
    return SBOX[2047 - 8*int'(x) -: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] v;
    v = 8'h01;
    for (int i = 1; i < int'(r); i++) v = xt(v);
    return v;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] b);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = sb(b[127-8*i -: 8]);
    return r;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] b);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int rw = 0; rw < 4; rw++)
        r[127-8*(rw+4*c) -: 8] = b[127-8*(rw+4*((c+rw)%4)) -: 8];
    return r;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] b);
    logic [127:0] r;
    logic [7:0] a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = b[127-32*c -: 8];
      a1 = b[119-32*c -: 8];
      a2 = b[111-32*c -: 8];
      a3 = b[103-32*c -: 8];
      r[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      r[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      r[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      r[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
    return r;
  endfunction

  function automatic logic [127:0] next_key(input logic [127:0] k, input logic [3:0] r);
    logic [31:0] w0, w1, w2, w3, rot, t;
    w0  = k[127:96];
    w1  = k[95:64];
    w2  = k[63:32];
    w3  = k[31:0];
    rot = {w3[23:0], w3[31:24]};
    t   = {sb(rot[31:24]), sb(rot[23:16]), sb(rot[15:8]), sb(rot[7:0])} ^ {rcon(r), 24'h0};
    w0  = w0 ^ t;
    w1  = w1 ^ w0;
    w2  = w2 ^ w1;
    w3  = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  always_comb begin
    rnd_keyout = next_key(rnd_key, rnd_rc);
    rnd_out    = mix_columns(shift_rows(sub_bytes(rnd_data))) ^ rnd_keyout;
    fin_out    = shift_rows(sub_bytes(rnd_data)) ^ rnd_keyout;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_wait(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_no_done", done, 0);
      chk("idle_busy", busy, 0);
    end
  endtask

  // One operation from start to the done cycle. inj_rc != 0 pulses start while
  // that round is being requested. prev_ct is the ciphertext that must be held
  // until the final-round capture.
  task automatic run_op(input logic [127:0] pt, input logic [127:0] k, input bit stall,
                        input int inj_rc, input logic [127:0] prev_ct, output int lat);
    int           cyc;
    logic [3:0]   exp_rc;
    logic         pend;
    logic [127:0] sd, sk;
    logic [3:0]   src;
    @(negedge clk);
    start = 1'b1; plaintext = pt; key = k;
    @(negedge clk);
    start = 1'b0; plaintext = '0; key = '0;
    cyc = 1; exp_rc = 4'd1; pend = 1'b0; sd = '0; sk = '0; src = '0;
    chk("load_busy", busy, 1);
    chk("load_rnd_start", rnd_start, 0);
    chk("load_data", rnd_data, pt ^ k);
    chk("load_key", rnd_key, k);
    chk("load_rc", rnd_rc, 1);
    while (!done && cyc < 80) begin
      if (pend) begin
        chk("stall_data", rnd_data, sd);
        chk("stall_key", rnd_key, sk);
        chk("stall_rc", rnd_rc, src);
        chk("stall_rnd_start", rnd_start, 1);
      end
      chk("op_busy", busy, 1);
      chk("op_ct_held", ciphertext, prev_ct);
      rnd_next = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      start    = (inj_rc != 0) && rnd_start && (rnd_rc == 4'(inj_rc));
      if (rnd_start && rnd_next) begin
        chk("rc_seq", rnd_rc, exp_rc);
        exp_rc++;
      end
      pend = rnd_start && !rnd_next;
      sd   = rnd_data;
      sk   = rnd_key;
      src  = rnd_rc;
      @(negedge clk);
      cyc++;
    end
    start    = 1'b0;
    rnd_next = 1'b1;
    lat      = cyc;
    chk("done_seen", done, 1);
    chk("round_count", exp_rc, 11);
    chk("done_busy", busy, 0);
    chk("done_rnd_start", rnd_start, 0);
  endtask

  initial begin
    int lat, cyc, d1, d2;
    rst_n = 1'b0; start = 1'b0; rnd_next = 1'b1; plaintext = '0; key = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rnd_start", rnd_start, 0);
    chk("rst_ct", ciphertext, 0);
    chk("rst_data", rnd_data, 0);
    chk("rst_key", rnd_key, 0);
    chk("rst_rc", rnd_rc, 0);
    rst_n = 1'b1;
    idle_wait(3);

    // FIPS-197 C.1 vector, datapath always ready
    run_op(PT1, K1, 1'b0, 0, 128'h0, lat);
    chk("c1_latency", lat, 12);
    chk("c1_ct", ciphertext, CT1);
    idle_wait(3);

    // FIPS-197 appendix B vector
    run_op(PT2, K2, 1'b0, 0, CT1, lat);
    chk("b_latency", lat, 12);
    chk("b_ct", ciphertext, CT2);
    idle_wait(3);

    // Same vector with random stalls
    run_op(PT2, K2, 1'b1, 0, CT2, lat);
    chk("stall_ct", ciphertext, CT2);
    idle_wait(5);

    // start pulsed during round 5 is ignored
    run_op(PT1, K1, 1'b0, 5, CT2, lat);
    chk("inj_latency", lat, 12);
    chk("inj_ct", ciphertext, CT1);
    idle_wait(15);

    // Reset during round 6 aborts with everything cleared
    @(negedge clk);
    start = 1'b1; plaintext = PT2; key = K2;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!(rnd_start && rnd_rc == 4'd6) && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("reached_rc6", rnd_rc, 6);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_rnd_start", rnd_start, 0);
    chk("arst_data", rnd_data, 0);
    chk("arst_key", rnd_key, 0);
    chk("arst_ct", ciphertext, 0);
    chk("arst_rc", rnd_rc, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle_wait(10);
    run_op(PT1, K1, 1'b0, 0, 128'h0, lat);
    chk("post_rst_latency", lat, 12);
    chk("post_rst_ct", ciphertext, CT1);
    idle_wait(3);

    // start held high: two back-to-back operations
    @(negedge clk);
    start = 1'b1; plaintext = PT1; key = K1;
    @(negedge clk);
    plaintext = PT2; key = K2;
    cyc = 1; d1 = 0; d2 = 0;
    while (d2 == 0 && cyc < 80) begin
      if (done) begin
        if (d1 == 0) begin
          d1 = cyc;
          chk("b2b_ct1", ciphertext, CT1);
          chk("b2b_busy_done1", busy, 0);
        end else begin
          d2 = cyc;
          start = 1'b0;
        end
      end else if (d1 != 0) begin
        chk("b2b_ct_hold", ciphertext, CT1);
      end
      if (d2 == 0) begin
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    chk("b2b_first_done", d1, 12);
    chk("b2b_gap", d2 - d1, 13);
    chk("b2b_ct2", ciphertext, CT2);
    idle_wait(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
